// File: rtl/iir_result_buffer_pkg.sv
// iir_result_buffer_pkg: shared state encoding, default widths and signed peak compare
package iir_result_buffer_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 11;
  typedef enum logic [1:0] {IDLE, CAPTURE, READY, DRAIN} state_t;
  function automatic logic [DEF_DATA_W-1:0] pick(input logic [DEF_DATA_W-1:0] a, b, input logic want_max);
    return (($signed(a) > $signed(b)) == want_max) ? a : b;
  endfunction
endpackage

// File: rtl/iir_result_buffer_if.sv
// iir_result_buffer_if: valid/ready drain stream towards the host link
interface iir_result_buffer_if #(parameter int DATA_W = 16);
  logic valid, ready, last;
  logic [DATA_W-1:0] data;
  modport master(output valid, data, last, input ready);
  modport slave(input valid, data, last, output ready);
endinterface

// File: rtl/iir_sdp_ram.sv
// iir_sdp_ram: simple dual-port RAM, one write port, one registered read port
module iir_sdp_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/iir_result_buffer.sv
// iir_result_buffer: captures filtered samples with signed peaks, then replays them on a valid/ready stream
module iir_result_buffer
  import iir_result_buffer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              stable_in,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic              in_done,
  input  logic              rd_start,
  iir_result_buffer_if.master m,
  output logic [ADDR_W:0]   count,
  output logic [DATA_W-1:0] peak_max,
  output logic [DATA_W-1:0] peak_min,
  output logic              busy,
  output logic              drain_done,
  output logic              overflow,
  output logic              addr_err
);
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
  state_t state, state_n;
  logic fresh, accept, pop, done_beat, start, issue;
  logic pend_v, r_v, r_last, s_v, s_last, o_v, o_last;
  logic [DATA_W-1:0] pend_d, s_d, o_d, ram_q;
  logic [ADDR_W-1:0] wr_ptr, wa;
  logic [ADDR_W:0] rd_cnt, rd_eff, cnt_eff;
  logic [1:0] occ;
  // count/peaks of a finished run stay visible until a new capture accepts its first sample
  assign wa        = fresh ? '0 : wr_ptr;
  assign cnt_eff   = fresh ? '0 : count;
  assign accept    = state == CAPTURE && in_valid && stable_in && cnt_eff < FULL;
  assign pop       = o_v && m.ready;
  assign done_beat = pop && o_last;
  assign start     = state == READY && rd_start;
  assign rd_eff    = start ? '0 : rd_cnt;
  // reads are issued only when output + skid slot can absorb everything in flight
  assign occ       = 2'(o_v) + 2'(s_v) + 2'(r_v) - 2'(pop);
  assign issue     = start ? count != '0 : state == DRAIN && rd_cnt < count && occ < 2'd2;
  assign busy      = state == CAPTURE || state == DRAIN;
  assign m.valid   = o_v;
  assign m.data    = o_d;
  assign m.last    = o_last;
  iir_sdp_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk(clk), .we(accept), .waddr(wa), .wdata(in_data),
    .re(issue), .raddr(rd_eff[ADDR_W-1:0]), .rdata(ram_q)
  );
  always_comb begin
    state_n = state;
    if (state == IDLE && stable_in) state_n = CAPTURE;
    if (state == CAPTURE && in_done) state_n = READY;
    if (start) state_n = count != '0 ? DRAIN : IDLE;
    if (state == DRAIN && done_beat) state_n = IDLE;
    if (clear) state_n = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {fresh, wr_ptr, count, rd_cnt, peak_max, peak_min, pend_v, pend_d} <= '0;
      {r_v, r_last, s_v, s_last, s_d, o_v, o_last, o_d} <= '0;
      {drain_done, overflow, addr_err} <= '0;
    end else if (clear) begin
      {fresh, wr_ptr, count, rd_cnt, peak_max, peak_min, pend_v, pend_d} <= '0;
      {r_v, r_last, s_v, s_last, s_d, o_v, o_last, o_d} <= '0;
      {drain_done, overflow, addr_err} <= '0;
    end else begin
      fresh <= (state == IDLE && stable_in) || (fresh && !accept);
      if (accept) begin
        wr_ptr   <= wa + 1'b1;
        count    <= cnt_eff + 1'b1;
        addr_err <= addr_err | (in_addr != wa + 1'b1);
      end
      if (accept && cnt_eff == '0) begin
        peak_max <= in_data;
        peak_min <= in_data;
      end else if (pend_v) begin
        peak_max <= pick(peak_max, pend_d, 1'b1);
        peak_min <= pick(peak_min, pend_d, 1'b0);
      end
      pend_v     <= accept && cnt_eff != '0;
      pend_d     <= in_data;
      overflow   <= overflow | (in_valid && !accept);
      drain_done <= (start && count == '0) || (state == DRAIN && done_beat);
      if (issue) rd_cnt <= rd_eff + 1'b1;
      r_v    <= issue;
      r_last <= issue && rd_eff + 1'b1 == count;
      if (!o_v || pop) begin
        o_v    <= s_v | r_v;
        o_d    <= s_v ? s_d : ram_q;
        o_last <= s_v ? s_last : r_last;
        s_v    <= s_v & r_v;
      end else if (r_v) s_v <= 1'b1;
      if (r_v) begin
        s_d    <= ram_q;
        s_last <= r_last;
      end
    end
  end
endmodule

// File: tb/tb_iir_result_buffer.sv
// tb_iir_result_buffer: directed capture/drain scenarios with hand-computed expectations
module tb_iir_result_buffer;
  logic clk = 0, rst_n = 0, clear = 0, stable_in = 0, in_valid = 0, in_done = 0, rd_start = 0;
  logic [15:0] in_data = 0;
  logic [10:0] in_addr = 0;
  logic [11:0] count;
  logic [15:0] peak_max, peak_min;
  logic busy, drain_done, overflow, addr_err;
  int total = 0, bad = 0;
  logic [15:0] exp_q[$];
  iir_result_buffer_if #(.DATA_W(16)) m();
  iir_result_buffer dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .stable_in(stable_in), .in_valid(in_valid),
    .in_data(in_data), .in_addr(in_addr), .in_done(in_done), .rd_start(rd_start), .m(m),
    .count(count), .peak_max(peak_max), .peak_min(peak_min), .busy(busy),
    .drain_done(drain_done), .overflow(overflow), .addr_err(addr_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [15:0] d, input logic [10:0] a, input logic keep);
    in_valid = 1; in_data = d; in_addr = a;
    tick();
    in_valid = 0;
    if (keep) exp_q.push_back(d);
  endtask
  task automatic restart();
    clear = 1; tick(); clear = 0;
    exp_q.delete();
    stable_in = 1; tick();
  endtask
  task automatic finish_capture();
    in_done = 1; tick(); in_done = 0; stable_in = 0;
  endtask
  task automatic drain(input logic [3:0] pat);
    int n = exp_q.size(), got = 0, cyc = 0;
    logic stall = 0;
    logic [15:0] held = 0;
    rd_start = 1; tick(); rd_start = 0;
    chk("lat1", {31'd0, m.valid}, 0);
    tick();
    chk("lat2", {31'd0, m.valid}, 1);
    while (got < n && cyc < 4*n + 16) begin
      m.ready = pat[cyc % 4];
      if (stall) chk("hold", {m.valid, m.data}, {1'b1, held});
      stall = m.valid && !m.ready;
      held = m.data;
      if (m.valid && m.ready) begin
        chk("beat", {m.last, m.data}, {got == n-1, exp_q[got]});
        got++;
      end
      cyc++;
      tick();
    end
    m.ready = 0;
    chk("beats", got, n);
    chk("done", {drain_done, m.valid, busy}, 3'b100);
    tick();
    chk("done_pulse", {31'd0, drain_done}, 0);
  endtask
  initial begin
    m.ready = 0;
    #12;
    chk("rst_vals", {count, peak_max}, 0);
    chk("rst_min", peak_min, 0);
    chk("rst_flags", {m.valid, m.last, busy, drain_done, overflow, addr_err}, 0);
    rst_n = 1;
    tick();
    // full capture of 2047 ramp samples
    stable_in = 1; tick();
    for (int n = 0; n < 2047; n++) send(16'(n - 1024), 11'(n + 1), 1);
    chk("busy_cap", {31'd0, busy}, 1);
    finish_capture();
    chk("cnt2047", count, 2047);
    chk("pmin", peak_min, 16'hFC00);
    chk("pmax", peak_max, 1022);
    chk("flags1", {addr_err, overflow, busy}, 0);
    drain(4'hF);
    // backpressure
    restart();
    for (int n = 0; n < 8; n++) send(16'(100 + 7*n), 11'(n + 1), 1);
    finish_capture();
    chk("bp_peaks", {peak_max, peak_min}, {16'd149, 16'd100});
    drain(4'b1001);
    // overflow: one sample past full, one in READY
    restart();
    for (int n = 0; n < 2049; n++) send(16'(n), 11'(n + 1), n < 2048);
    finish_capture();
    send(16'hBEEF, 0, 0);
    chk("cnt_full", count, 2048);
    chk("ovf", {overflow, addr_err}, 2'b10);
    chk("ovf_peaks", {peak_max, peak_min}, {16'd2047, 16'd0});
    drain(4'hF);
    // address mismatch
    restart();
    send(10, 1, 1); send(20, 2, 1);
    chk("aerr0", {31'd0, addr_err}, 0);
    send(30, 5, 1);
    chk("aerr1", {31'd0, addr_err}, 1);
    send(40, 4, 1);
    finish_capture();
    chk("cnt4", count, 4);
    drain(4'hF);
    // empty drain
    restart();
    stable_in = 0;
    finish_capture();
    chk("empty_ready", {count, busy}, 0);
    rd_start = 1; tick(); rd_start = 0;
    chk("empty_done", {drain_done, m.valid}, 2'b10);
    tick();
    chk("empty_after", {drain_done, m.valid}, 0);
    stable_in = 1; tick();
    chk("empty_idle", {31'd0, busy}, 1);
    // clear wins over rd_start
    restart();
    send(16'hFFFB, 1, 1); send(7, 2, 1); send(3, 3, 1);
    finish_capture();
    chk("clr_pre", {count, peak_max, peak_min}, {12'd3, 16'd7, 16'hFFFB});
    clear = 1; rd_start = 1; tick(); clear = 0; rd_start = 0;
    chk("clr_vals", {count, peak_max}, 0);
    chk("clr_min", peak_min, 0);
    tick();
    chk("clr_state", {busy, m.valid, drain_done, overflow, addr_err}, 0);
    // asynchronous reset mid-drain
    restart();
    for (int n = 0; n < 5; n++) send(16'(n + 1), 11'(n + 1), 1);
    finish_capture();
    rd_start = 1; tick(); rd_start = 0;
    tick(3);
    chk("mid_valid", {m.valid, busy}, 2'b11);
    #2 rst_n = 0;
    #1;
    chk("ar_vals", {count, peak_max}, 0);
    chk("ar_min", peak_min, 0);
    chk("ar_flags", {m.valid, m.last, m.data, busy, drain_done, overflow, addr_err}, 0);
    rst_n = 1;
    tick();
    chk("ar_after", {m.valid, busy}, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/iir_result_buffer.md
Name: iir_result_buffer

Overview:
- Sits directly downstream of the IIR filter control stage.
- Captures the filtered sample stream (valid/data/addr) into an on-chip buffer and tracks signed peak min/max.
- Once the filter signals done, replays the buffer on a valid/ready stream to the host, UART or DAC link.
- Decouples the free-running filter from a slower consumer.

Parameters:
- DATA_W, 16, sample width (signed two's complement)
- ADDR_W, 11, buffer address width
- DEPTH, 2048, buffer depth in samples (must equal 2**ADDR_W)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous clear; returns block to IDLE and zeroes count, flags and peaks
- stable_in  in  1  filter settled; capture is enabled only while high
- in_valid  in  1  sample strobe from filter control
- in_data  in  DATA_W  filtered sample
- in_addr  in  ADDR_W  sample address from filter control (post-incremented: first sample carries 1)
- in_done  in  1  one-cycle filter-done pulse
- rd_start  in  1  begin drain; honoured only in READY
- m_valid  out  1  output sample valid
- m_ready  in  1  consumer ready
- m_data  out  DATA_W  output sample
- m_last  out  1  high with the final drained sample
- count  out  ADDR_W+1  samples captured
- peak_max  out  DATA_W  largest signed sample captured
- peak_min  out  DATA_W  smallest signed sample captured
- busy  out  1  high in CAPTURE or DRAIN
- drain_done  out  1  one-cycle pulse when drain completes
- overflow  out  1  sticky: sample dropped because buffer was full or block was not capturing
- addr_err  out  1  sticky: in_addr != (wr_ptr+1) mod DEPTH on an accepted write

Behaviour:
- Reset / clear:
  - All outputs are 0; state is IDLE; wr_ptr and rd_ptr are 0.
  - clear has priority over every other input in the same cycle.
  - Buffer RAM contents are not reset.
- IDLE:
  - Goes to CAPTURE when stable_in=1.
  - in_valid while in IDLE sets overflow.
- CAPTURE:
  - Accept condition: in_valid && stable_in && count<DEPTH. An accepted sample is written to RAM[wr_ptr]; then wr_ptr and count increment.
  - in_addr is checked on every accepted write; a mismatch sets addr_err, and the write still uses wr_ptr.
  - in_valid with count==DEPTH, or with stable_in=0, drops the sample and sets overflow.
  - Peaks: the first accepted sample loads both peak_max and peak_min. Later samples are compared signed and update the peaks one cycle after acceptance.
  - in_done moves the state to READY. If in_valid and in_done arrive in the same cycle, the sample is accepted first.
- READY:
  - Holds count and peaks.
  - in_valid sets overflow and the data is discarded.
  - rd_start with count>0 moves the state to DRAIN and sets rd_ptr=0.
  - rd_start with count=0 pulses drain_done on the next cycle and moves the state to IDLE; m_valid never asserts.
- DRAIN:
  - RAM read latency is 1 cycle; output is a registered stage plus one prefetch slot.
  - First m_valid occurs 2 cycles after the rd_start cycle.
  - While m_valid && !m_ready, m_data and m_last hold stable.
  - With m_ready held high, samples are produced one per cycle with no bubbles.
  - m_last is asserted with sample index count-1.
  - Handshake on the m_last beat drops m_valid on the next cycle, pulses drain_done, and moves the state to IDLE. count and peaks stay readable until the next capture starts (first accepted sample) or clear.
  - rd_start and in_valid are ignored in DRAIN; in_valid sets overflow.
- Asynchronous reset mid-capture or mid-drain aborts immediately; no partial handshake is completed.
- Widths: count is ADDR_W+1 bits so that DEPTH is representable; pointers wrap modulo DEPTH.

Decomposition:
- Shared package: state encoding (IDLE, CAPTURE, READY, DRAIN), DATA_W/ADDR_W defaults, and a signed min/max compare function.
- One sub-module: iir_sdp_ram. It is a simple dual-port RAM with a 1-write port and a 1-read port, registered read, 1-cycle latency, and is synthesisable to block RAM.
- The FSM, pointers, peaks and output skid stage stay in the top block.

Test Plan:
- Capture and drain:
  - Stimulus: stable_in=1; 2047 samples with in_data=n-1024 and in_addr=n+1 (n=0..2046); then in_done; then rd_start with m_ready=1.
  - Required: count=2047, peak_min=-1024, peak_max=1022; 2047 beats identical to input order; m_last on beat 2046; drain_done one cycle later; addr_err=0, overflow=0.
- Backpressure:
  - Stimulus: drain 8 samples while toggling m_ready 1,0,0,1.
  - Required: m_data held during stalls; no duplicated or lost beats; first m_valid 2 cycles after rd_start.
- Overflow:
  - Stimulus: 2049 valid samples in CAPTURE; one more in_valid after in_done.
  - Required: count=2048 and overflow=1; RAM[2047] holds sample 2047, not sample 2048.
- Address check:
  - Stimulus: send 4 samples with in_addr=1,2,5,4.
  - Required: addr_err=1 after the third sample; all 4 samples stored at 0..3.
- Empty drain:
  - Stimulus: in_done with no samples, then rd_start.
  - Required: m_valid stays 0; drain_done pulses 1 cycle after rd_start; state returns to IDLE.
- Reset and clear:
  - Stimulus: assert rst_n=0 mid-drain; separately, assert clear together with rd_start in READY.
  - Required: all outputs 0 and state IDLE; clear wins over rd_start.
